// File: rtl/uart_pkg.sv
// Shared types and helpers for the uart_ip receive and transmit paths.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_rx_state_e;

  // Parity bit value that makes data+parity even (odd=0) or odd (odd=1).
  function automatic logic uart_parity(input logic [UART_DATA_W-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Sample-tick generator: one tick every baud_div clk cycles (0 behaves as 1).
// Latency: first tick baud_div cycles after clr drops.
// Backpressure: none; clr holds the counter at 0 and suppresses ticks.
module uart_baud_tick #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             clr,
  input  logic [DIV_W-1:0] baud_div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_eff;

  assign div_eff = (baud_div == '0) ? DIV_W'(1) : baud_div;

  // div_q only follows baud_div at a wrap, so a mid-period change cannot skip the terminal count
  assign tick = !clr && (cnt == div_q - DIV_W'(1));

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cnt   <= '0;
      div_q <= DIV_W'(1);
    end else if (clr || tick) begin
      cnt   <= '0;
      div_q <= div_eff;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled 8N1/8E1/8O1/8N2 deframer into a one-entry valid/ready holding register.
// Latency: rx_valid rises 1 clk after the last stop-bit decision sample.
// Backpressure: holding register full at frame end -> byte dropped, overrun_err pulses. UART_RX_MAJORITY_EN: 2-of-3 bit vote.
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE  = 16,
  parameter int DIV_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   arst_n,
  input  logic                   rx,
  input  logic                   rx_en,
  input  logic [DIV_W-1:0]       baud_div,
  input  logic                   parity_en,
  input  logic                   parity_odd,
  input  logic                   stop2,
  output logic [UART_DATA_W-1:0] rx_data,
  output logic                   rx_valid,
  input  logic                   rx_ready,
  output logic                   frame_err,
  output logic                   parity_err,
  output logic                   overrun_err,
  output logic                   busy
);

  localparam int S_W = $clog2(OVERSAMPLE);
  localparam int B_W = $clog2(UART_DATA_W);
  localparam logic [S_W-1:0] S_LAST   = S_W'(OVERSAMPLE - 1);
`ifdef UART_RX_MAJORITY_EN
  localparam logic [S_W-1:0] S_PRE0   = S_W'(OVERSAMPLE / 2 - 1);
  localparam logic [S_W-1:0] S_PRE1   = S_W'(OVERSAMPLE / 2);
  localparam logic [S_W-1:0] S_DECIDE = S_W'(OVERSAMPLE / 2 + 1);
`else
  localparam logic [S_W-1:0] S_DECIDE = S_W'(OVERSAMPLE / 2);
`endif
  localparam logic [B_W-1:0] B_LAST   = B_W'(UART_DATA_W - 1);

  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    rx_s;
  logic                    rx_prev;
  uart_rx_state_e          state;
  logic [S_W-1:0]          s_cnt;
  logic [B_W-1:0]          bit_cnt;
  logic                    stop_idx;
  logic [UART_DATA_W-1:0]  shreg;
  logic                    ferr_q;
  logic                    perr_q;
  logic                    tick;
  logic                    sample_now;
  logic                    bit_val;
  logic                    frame_last;
  logic                    frame_done;
  logic                    load;
  logic                    overrun;

  assign rx_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sync_q  <= '1;
      rx_prev <= 1'b1;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], rx};
      rx_prev <= rx_s;
    end
  end

  // Held clear while idle so tick phase is aligned to the detected start edge
  uart_baud_tick #(
    .DIV_W (DIV_W)
  ) u_tick (
    .clk      (clk),
    .arst_n   (arst_n),
    .clr      (state == IDLE),
    .baud_div (baud_div),
    .tick     (tick)
  );

  assign sample_now = tick && (s_cnt == S_DECIDE);

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] maj_q;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      maj_q <= 2'b11;
    end else if (tick && (s_cnt == S_PRE0 || s_cnt == S_PRE1)) begin
      maj_q <= {maj_q[0], rx_s};
    end
  end

  assign bit_val = (maj_q[1] & maj_q[0]) | (maj_q[1] & rx_s) | (maj_q[0] & rx_s);
`else
  assign bit_val = rx_s;
`endif

  assign frame_last = (state == STOP) && (!stop2 || stop_idx);
  assign frame_done = rx_en && sample_now && frame_last;

  // State changes at the decision sample; s_cnt keeps running so bit boundaries stay put
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state    <= IDLE;
      s_cnt    <= '0;
      bit_cnt  <= '0;
      stop_idx <= 1'b0;
      shreg    <= '0;
      ferr_q   <= 1'b0;
      perr_q   <= 1'b0;
    end else if (!rx_en) begin
      state <= IDLE;
      s_cnt <= '0;
    end else begin
      if (state == IDLE) begin
        s_cnt <= '0;
      end else if (tick) begin
        s_cnt <= (s_cnt == S_LAST) ? '0 : s_cnt + S_W'(1);
      end

      case (state)
        IDLE: begin
          if (rx_prev && !rx_s) begin
            state    <= START;
            bit_cnt  <= '0;
            stop_idx <= 1'b0;
            ferr_q   <= 1'b0;
            perr_q   <= 1'b0;
          end
        end
        START: begin
          if (sample_now) begin
            state <= bit_val ? IDLE : DATA;
          end
        end
        DATA: begin
          if (sample_now) begin
            shreg   <= {bit_val, shreg[UART_DATA_W-1:1]};
            bit_cnt <= bit_cnt + B_W'(1);
            if (bit_cnt == B_LAST) begin
              state <= parity_en ? PARITY : STOP;
            end
          end
        end
        PARITY: begin
          if (sample_now) begin
            perr_q <= (bit_val != uart_parity(shreg, parity_odd));
            state  <= STOP;
          end
        end
        STOP: begin
          if (sample_now) begin
            if (!bit_val) begin
              ferr_q <= 1'b1;
            end
            if (frame_last) begin
              state <= IDLE;
            end else begin
              stop_idx <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign load    = frame_done && (!rx_valid || rx_ready);
  assign overrun = frame_done && rx_valid && !rx_ready;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      parity_err  <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      frame_err   <= frame_done && (ferr_q || !bit_val);
      parity_err  <= frame_done && perr_q;
      overrun_err <= overrun;
      if (load) begin
        rx_data  <= shreg;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule
